// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : issue/response sequencer sitting directly in front of the `alu`.
//
// Accepts one request (opcode + two N-bit operands) and holds the operands
// stable on the ALU inputs. It pulses alu_en for one cycle, then waits the
// opcode-dependent ALU latency. It captures the 2N-bit result and 3-bit flags
// into a response register. Only one operation is in flight at a time.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer keeps valid and its payload
// stable until that edge. The consumer may drive ready at any time.
// req_ready may depend combinationally on rsp_ready: a new request is taken
// in the same cycle the previous response is consumed.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake; req_op, req_a, req_b payload
//   alu_en                 one-cycle enable pulse to the ALU
//   alu_op, alu_a, alu_b   registered opcode/operands to the ALU
//   alu_y, alu_flag        ALU result (2N bits) and flags (3 bits)
//   rsp_valid/rsp_ready    response handshake; rsp_y, rsp_flag, rsp_op payload
//   ops_done               completed-operation count (see macro below)
//   state_dbg              current FSM state (0 IDLE, 1 EXEC, 2 WAIT, 3 RESP)
//
// Optional feature macro: ALU_SEQ_PERF_EN
//   defined   : ops_done counts response handshakes, saturating at 16'hFFFF
//   undefined : ops_done is tied to 0
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int N         = 32,
  parameter int SHIFT_LAT = 1,
  parameter int MUL_LAT   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2:0]     req_op,
  input  logic [N-1:0]   req_a,
  input  logic [N-1:0]   req_b,
  output logic           alu_en,
  output logic [2:0]     alu_op,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [2*N-1:0] alu_y,
  input  logic [2:0]     alu_flag,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_y,
  output logic [2:0]     rsp_flag,
  output logic [2:0]     rsp_op,
  output logic [15:0]    ops_done,
  output logic [1:0]     state_dbg
);

  // Latencies below 1 behave as 1.
  localparam int SL   = (SHIFT_LAT < 1) ? 1 : SHIFT_LAT;
  localparam int ML   = (MUL_LAT < 1) ? 1 : MUL_LAT;
  localparam int MAXL = (SL > ML) ? SL : ML;
  // The counter only ever holds L-1, so clog2(MAXL) bits are enough.
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0] SL_M1 = CW'(SL - 1);
  localparam logic [CW-1:0] ML_M1 = CW'(ML - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [2*N-1:0]   rsp_y_q, rsp_y_d;
  logic [2:0]       rsp_flag_q, rsp_flag_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic             accept;
  logic             capture;

  // Counter preload: latency minus one for the given opcode.
  function automatic logic [CW-1:0] lat_m1(input logic [2:0] op);
    case (op)
      3'b101, 3'b110: lat_m1 = SL_M1;
      3'b111:         lat_m1 = ML_M1;
      default:        lat_m1 = '0;
    endcase
  endfunction

  // In RESP a new request is admitted only in the cycle the response leaves.
  assign req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_y_d    = rsp_y_q;
    rsp_flag_d = rsp_flag_q;
    rsp_op_d   = rsp_op_q;
    capture    = 1'b0;
    alu_en     = 1'b0;
    rsp_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = req_valid ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Operands are only replaced on an accepted request. This keeps them
    // stable through EXEC, WAIT and RESP.
    if (accept) begin
      op_d  = req_op;
      a_d   = req_a;
      b_d   = req_b;
      cnt_d = lat_m1(req_op);
    end

    if (capture) begin
      rsp_y_d    = alu_y;
      rsp_flag_d = alu_flag;
      rsp_op_d   = op_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_y_q    <= '0;
      rsp_flag_q <= '0;
      rsp_op_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_y_q    <= rsp_y_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_op_q   <= rsp_op_d;
    end
  end

  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flag  = rsp_flag_q;
  assign rsp_op    = rsp_op_q;
  assign state_dbg = state_q;

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] ops_q, ops_d;

  // Count response handshakes and saturate rather than wrap.
  always_comb begin
    ops_d = ops_q;
    if (rsp_valid && rsp_ready && (ops_q != 16'hFFFF)) ops_d = ops_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ops_q <= '0;
    else     ops_q <= ops_d;
  end

  assign ops_done = ops_q;
`else
  assign ops_done = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int N   = 32;
  localparam int SLP = 1;
  localparam int MLP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [N-1:0]  req_a = '0;
  logic [N-1:0]  req_b = '0;
  logic          alu_en;
  logic [2:0]    alu_op;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [63:0]   alu_y;
  logic [2:0]    alu_flag;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [63:0]   rsp_y;
  logic [2:0]    rsp_flag;
  logic [2:0]    rsp_op;
  logic [15:0]   ops_done;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;
  int exp_ops = 0;
  int en_cnt = 0;
  logic [63:0] exp_q[$];

  alu_seq #(.N(N), .SHIFT_LAT(SLP), .MUL_LAT(MLP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flag(rsp_flag), .rsp_op(rsp_op),
    .ops_done(ops_done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  // The result is valid only once the opcode's latency has elapsed since the
  // en pulse. Before that the model drives garbage.
  logic [7:0] age = '0;
  logic [8:0] mdl_k;
  logic [8:0] mdl_lat;
  logic       mdl_ok;
  logic [63:0] mdl_res;

  function automatic logic [63:0] model_y(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: model_y = {32'd0, a + b};
      3'd1: model_y = {32'd0, a - b};
      3'd2: model_y = {32'd0, a & b};
      3'd3: model_y = {32'd0, a | b};
      3'd4: model_y = {32'd0, ~a};
      3'd5: model_y = {32'd0, a << b};
      3'd6: model_y = {32'd0, a >> b};
      default: model_y = {32'd0, a} * {32'd0, b};
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_en) age <= 8'd1;
    else if (age != 8'd0 && age != 8'hFF) age <= age + 8'd1;
    if (alu_en) en_cnt <= en_cnt + 1;
  end

  assign mdl_k    = alu_en ? 9'd1 : ({1'b0, age} + 9'd1);
  assign mdl_lat  = (alu_op == 3'd7) ? 9'(MLP) : ((alu_op == 3'd5 || alu_op == 3'd6) ? 9'(SLP) : 9'd1);
  assign mdl_ok   = (mdl_k >= mdl_lat);
  assign mdl_res  = model_y(alu_op, alu_a, alu_b);
  assign alu_y    = mdl_ok ? mdl_res : 64'hDEAD_BEEF_DEAD_BEEF;
  assign alu_flag = mdl_ok ? ((mdl_res == 64'd0) ? 3'b001 : 3'b010) : 3'b111;

  function automatic logic [15:0] ops_exp();
`ifdef ALU_SEQ_PERF_EN
    return 16'(exp_ops);
`else
    return 16'd0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
  endtask

  // Edges from now until rsp_valid is seen; -1 if the budget expires.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!rsp_valid && cyc < 50);
    if (!rsp_valid) cyc = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL rst_alu_en: got %0b want 0", alu_en); end
    checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL rst_ops_done: got %0d want 0", ops_done); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    // Park a response in RESP, then reset asynchronously mid-cycle.
    begin
      int cyc;
      start_req(3'd0, 32'd5, 32'd7);
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_rsp(cyc);
      checks++; if (rsp_y !== 64'd12) begin errors++; $display("FAIL rst_pre_rsp_y: got %0h want c", rsp_y); end
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL async_req_ready: got %0b want 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL async_rsp_valid: got %0b want 0", rsp_valid); end
      checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL async_alu_en: got %0b want 0", alu_en); end
      checks++; if (rsp_y !== 64'd0) begin errors++; $display("FAIL async_rsp_y: got %0h want 0", rsp_y); end
      checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin errors++; $display("FAIL async_alu_regs: got a=%0h b=%0h op=%0d want 0", alu_a, alu_b, alu_op); end
      @(negedge clk);
      rst = 1'b0;
      exp_ops = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    int cyc;
    int en0;
    en0 = en_cnt;
    start_req(3'd0, 32'd5, 32'd7);
    rsp_ready = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_req_ready: got %0b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL add_alu_en: got %0b want 1", alu_en); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 3'd0) begin errors++; $display("FAIL add_operands: got a=%0d b=%0d op=%0d want 5 7 0", alu_a, alu_b, alu_op); end
    wait_rsp(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", cyc); end
    checks++; if (rsp_y !== 64'd12) begin errors++; $display("FAIL add_rsp_y: got %0h want c", rsp_y); end
    checks++; if (rsp_op !== 3'd0) begin errors++; $display("FAIL add_rsp_op: got %0d want 0", rsp_op); end
    checks++; if (rsp_flag !== 3'b010) begin errors++; $display("FAIL add_rsp_flag: got %0b want 010", rsp_flag); end
    checks++; if (en_cnt - en0 !== 1) begin errors++; $display("FAIL add_en_pulses: got %0d want 1", en_cnt - en0); end
    @(posedge clk); #1;
    exp_ops++;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_done: got %0b want 0", rsp_valid); end
    checks++; if (ops_done !== ops_exp()) begin errors++; $display("FAIL add_ops_done: got %0d want %0d", ops_done, ops_exp()); end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  t_op[6];
    logic [31:0] t_a[6];
    logic [31:0] t_b[6];
    logic [63:0] t_y[6];
    logic [2:0]  t_f[6];
    t_op = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    t_a  = '{32'd20, 32'hF0, 32'hF0, 32'hFFFF0000, 32'd1, 32'd256};
    t_b  = '{32'd5, 32'h0F, 32'h0F, 32'd0, 32'd4, 32'd4};
    t_y  = '{64'd15, 64'd0, 64'hFF, 64'h0000FFFF, 64'd16, 64'd16};
    t_f  = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010};
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int cyc;
      start_req(t_op[i], t_a[i], t_b[i]);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_rsp(cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL op%0d_latency: got %0d want 1", t_op[i], cyc); end
      checks++; if (rsp_y !== t_y[i]) begin errors++; $display("FAIL op%0d_rsp_y: got %0h want %0h", t_op[i], rsp_y, t_y[i]); end
      checks++; if (rsp_flag !== t_f[i] || rsp_op !== t_op[i]) begin errors++; $display("FAIL op%0d_flag_op: got %0b/%0d want %0b/%0d", t_op[i], rsp_flag, rsp_op, t_f[i], t_op[i]); end
      @(posedge clk); #1;
      exp_ops++;
    end
    checks++; if (ops_done !== ops_exp()) begin errors++; $display("FAIL ops_ops_done: got %0d want %0d", ops_done, ops_exp()); end
  endtask

  task automatic test_mul();
    logic [31:0] m_a[2];
    logic [31:0] m_b[2];
    logic [63:0] m_y[2];
    m_a = '{32'd3, 32'hFFFFFFFF};
    m_b = '{32'd4, 32'd2};
    m_y = '{64'd12, 64'h1_FFFF_FFFE};
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      int cyc;
      int en0;
      en0 = en_cnt;
      start_req(3'd7, m_a[i], m_b[i]);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_rsp(cyc);
      checks++; if (cyc !== MLP) begin errors++; $display("FAIL mul%0d_latency: got %0d want %0d", i, cyc, MLP); end
      checks++; if (rsp_y !== m_y[i]) begin errors++; $display("FAIL mul%0d_rsp_y: got %0h want %0h", i, rsp_y, m_y[i]); end
      checks++; if (rsp_op !== 3'd7) begin errors++; $display("FAIL mul%0d_rsp_op: got %0d want 7", i, rsp_op); end
      checks++; if (en_cnt - en0 !== 1) begin errors++; $display("FAIL mul%0d_en_pulses: got %0d want 1", i, en_cnt - en0); end
      checks++; if (alu_a !== m_a[i]) begin errors++; $display("FAIL mul%0d_alu_a_hold: got %0h want %0h", i, alu_a, m_a[i]); end
      @(posedge clk); #1;
      exp_ops++;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    start_req(3'd0, 32'd1, 32'd2);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    wait_rsp(cyc);
    checks++; if (cyc !== 1 || rsp_y !== 64'd3) begin errors++; $display("FAIL bp_first: got cyc=%0d y=%0h want 1 3", cyc, rsp_y); end
    // Offer a different request while the response is stalled.
    start_req(3'd1, 32'd9, 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_y !== 64'd3 || rsp_flag !== 3'b010) begin errors++; $display("FAIL bp_hold%0d: got v=%0b y=%0h f=%0b want 1 3 010", i, rsp_valid, rsp_y, rsp_flag); end
      checks++; if (req_ready !== 1'b0 || alu_a !== 32'd1 || alu_op !== 3'd0) begin errors++; $display("FAIL bp_noaccept%0d: got rdy=%0b a=%0h op=%0d want 0 1 0", i, req_ready, alu_a, alu_op); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_req_ready: got %0b want 1", req_ready); end
    @(posedge clk); #1;
    exp_ops++;
    req_valid = 1'b0;
    checks++; if (alu_en !== 1'b1 || alu_a !== 32'd9 || alu_op !== 3'd1) begin errors++; $display("FAIL bp_same_edge: got en=%0b a=%0h op=%0d want 1 9 1", alu_en, alu_a, alu_op); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_cleared: got %0b want 0", rsp_valid); end
    wait_rsp(cyc);
    checks++; if (cyc !== 1 || rsp_y !== 64'd5) begin errors++; $display("FAIL bp_second: got cyc=%0d y=%0h want 1 5", cyc, rsp_y); end
    @(posedge clk); #1;
    exp_ops++;
    checks++; if (ops_done !== ops_exp()) begin errors++; $display("FAIL bp_ops_done: got %0d want %0d", ops_done, ops_exp()); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_y;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_ops = 0;
    exp_q.delete();
    rsp_ready = 1'b1;
    start_req(3'd0, 32'd1, 32'd100);
    exp_q.push_back(64'd101);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k > 0) exp_ops++;
      checks++; if (alu_en !== 1'b1 || alu_a !== 32'(k + 1)) begin errors++; $display("FAIL b2b_issue%0d: got en=%0b a=%0h want 1 %0h", k, alu_en, alu_a, k + 1); end
      if (k < 7) begin
        req_a = 32'(k + 2);
        exp_q.push_back(64'(k + 102));
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      exp_y = exp_q.pop_front();
      checks++; if (rsp_valid !== 1'b1 || rsp_y !== exp_y) begin errors++; $display("FAIL b2b_rsp%0d: got v=%0b y=%0h want 1 %0h", k, rsp_valid, rsp_y, exp_y); end
    end
    @(posedge clk); #1;
    exp_ops++;
    checks++; if (rsp_valid !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL b2b_idle: got v=%0b st=%0d want 0 0", rsp_valid, state_dbg); end
    checks++; if (ops_done !== ops_exp()) begin errors++; $display("FAIL b2b_ops_done: got %0d want %0d", ops_done, ops_exp()); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    int seen;
    rsp_ready = 1'b1;
    start_req(3'd7, 32'd3, 32'd4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL mr_in_wait: got %0d want 2", state_dbg); end
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_ops = 0;
    checks++; if (state_dbg !== 2'd0 || alu_a !== 32'd0) begin errors++; $display("FAIL mr_cleared: got st=%0d a=%0h want 0 0", state_dbg, alu_a); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mr_no_rsp: got %0d want 0", seen); end
    start_req(3'd0, 32'd100, 32'd23);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(cyc);
    checks++; if (cyc !== 1 || rsp_y !== 64'd123) begin errors++; $display("FAIL mr_next_op: got cyc=%0d y=%0h want 1 7b", cyc, rsp_y); end
    @(posedge clk); #1;
    exp_ops++;
    checks++; if (ops_done !== ops_exp()) begin errors++; $display("FAIL mr_ops_done: got %0d want %0d", ops_done, ops_exp()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_add();
    test_alu_ops();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
